// File: rtl/servo_cmd_scheduler.sv
// Captures receiver words into a 4-deep command queue and executes them against servo state.
// Pop-to-update latency is one cycle; a full queue stalls the receiver and a stalled update holds the executor.
module servo_cmd_scheduler #(
  parameter int          NUM_SERVOS = 4,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [5:0]  HOME_POS   = 6'd32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  instruction,
  input  logic        instruction_ready,
  output logic        rx_reset,
  output logic        upd_valid,
  input  logic        upd_ready,
  output logic [1:0]  upd_id,
  output logic [5:0]  upd_pos,
  output logic [23:0] pos_flat,
  output logic [3:0]  enable_mask,
  output logic [2:0]  fifo_count,
  output logic        bad_op,
  output logic [1:0]  cap_state
);

  typedef enum logic [1:0] {ARMED = 2'd0, REARM = 2'd1, WAIT_CLR = 2'd2} cap_t;
  typedef enum logic [1:0] {EX_IDLE = 2'd0, EX_ISSUE = 2'd1, EX_HOME = 2'd2} ex_t;

  cap_t       cap_q, cap_d;
  ex_t        ex_q, ex_d;
  logic [9:0] fifo_mem [FIFO_DEPTH];
  logic [1:0] wr_ptr, rd_ptr;
  logic       push, pop, fifo_full;
  logic [9:0] head;
  logic [1:0] op, id;
  logic [5:0] val;
  logic [5:0] pos [NUM_SERVOS];

  assign fifo_full = (fifo_count == 3'(FIFO_DEPTH));
  assign head      = fifo_mem[rd_ptr];
  assign op        = head[9:8];
  assign id        = head[7:6];
  assign val       = head[5:0];
  assign cap_state = cap_q;

  for (genvar g = 0; g < NUM_SERVOS; g++) begin : g_flat
    assign pos_flat[6*g +: 6] = pos[g];
  end

  // Capture side: a word is taken once, then the receiver is re-armed and must drop its flag.
  always_comb begin
    cap_d    = cap_q;
    push     = 1'b0;
    rx_reset = 1'b0;
    case (cap_q)
      ARMED: if (instruction_ready && !fifo_full) begin
        push  = 1'b1;
        cap_d = REARM;
      end
      REARM: begin
        rx_reset = 1'b1;
        cap_d    = WAIT_CLR;
      end
      WAIT_CLR: if (!instruction_ready) cap_d = ARMED;
      default: cap_d = ARMED;
    endcase
  end

  always_comb begin
    ex_d = ex_q;
    pop  = 1'b0;
    case (ex_q)
      EX_IDLE: if (fifo_count != 3'd0) begin
        pop = 1'b1;
        if (op == 2'b00 && enable_mask[id]) ex_d = EX_ISSUE;
        else if (op == 2'b10)                ex_d = EX_HOME;
      end
      EX_ISSUE: if (upd_ready) ex_d = EX_IDLE;
      EX_HOME:  if (upd_ready && upd_id == 2'(NUM_SERVOS - 1)) ex_d = EX_IDLE;
      default:  ex_d = EX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= instruction;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q       <= ARMED;
      ex_q        <= EX_IDLE;
      wr_ptr      <= 2'd0;
      rd_ptr      <= 2'd0;
      fifo_count  <= 3'd0;
      upd_valid   <= 1'b0;
      upd_id      <= 2'd0;
      upd_pos     <= 6'd0;
      enable_mask <= 4'd0;
      bad_op      <= 1'b0;
      for (int i = 0; i < NUM_SERVOS; i++) pos[i] <= HOME_POS;
    end else begin
      cap_q     <= cap_d;
      ex_q      <= ex_d;
      upd_valid <= (ex_d != EX_IDLE);
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
      if (pop) begin
        case (op)
          2'b00: begin
            pos[id] <= val;
            if (enable_mask[id]) begin
              upd_id  <= id;
              upd_pos <= val;
            end
          end
          2'b01: enable_mask[id] <= val[0];
          2'b10: begin
            for (int i = 0; i < NUM_SERVOS; i++) pos[i] <= HOME_POS;
            upd_id  <= 2'd0;
            upd_pos <= HOME_POS;
          end
          default: bad_op <= 1'b1;
        endcase
      end else if (ex_q == EX_HOME && upd_ready && upd_id != 2'(NUM_SERVOS - 1)) begin
        // Home sweep walks ids in order, one per accepted transfer.
        upd_id  <= upd_id + 2'd1;
        upd_pos <= HOME_POS;
      end
    end
  end

endmodule
